// File: rtl/pulse_arbiter.sv
// Round-robin trigger scheduler: synchronizes N level inputs, latches rising
// edges as pending requests and issues them one at a time as fire strobes.
module pulse_arbiter #(
  parameter int N_CH     = 4,
  parameter int ID_W     = 2,
  parameter int DEADTIME = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   signal,
  input  logic              enable,
  input  logic              busy,
  input  logic              drop_clear,
  output logic              fire,
  output logic [ID_W-1:0]   fire_id,
  output logic [N_CH-1:0]   pending,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int DT_W  = $clog2(DEADTIME + 1);
  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t           state_reg;
  logic [ID_W-1:0]  last_reg;
  logic [DT_W-1:0]  cnt_reg;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  drop;
  logic [N_CH-1:0]  pending_next;
  logic [ID_W-1:0]  winner;
  logic             go;
  logic             found;
  logic [4:0]       drop_num;
  logic [SUM_W-1:0] drop_sum;
  logic [CNT_W-1:0] drop_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // sync_reg[0]=s1, [1]=s2, [2]=s3
      logic [2:0] sync_reg;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          sync_reg <= 3'b000;
        end else begin
          sync_reg <= {sync_reg[1:0], signal[gi]};
        end
      end
      assign rise[gi]         = sync_reg[1] & ~sync_reg[2];
      assign drop[gi]         = rise[gi] & pending[gi] & ~grant[gi];
      assign pending_next[gi] = rise[gi] | (pending[gi] & ~grant[gi]);
    end
  endgenerate

  // First pending channel after the last grant, in ascending modulo order.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_reg) + k) % N_CH;
      if (!found && (|(pending & (N_CH'(1) << idx)))) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign go    = (state_reg == IDLE) && (|pending) && enable && !busy;
  assign grant = (go && found) ? (N_CH'(1) << winner) : '0;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_num = drop_num + 5'(drop[i]);
    end
    drop_sum = SUM_W'(drop_count) + SUM_W'(drop_num);
    if (drop_clear) begin
      drop_next = '0;
    end else if (drop_sum > CNT_MAX) begin
      drop_next = CNT_MAX[CNT_W-1:0];
    end else begin
      drop_next = drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      fire       <= 1'b0;
      fire_id    <= '0;
      pending    <= '0;
      drop_count <= '0;
      last_reg   <= ID_W'(N_CH - 1);
      cnt_reg    <= '0;
    end else begin
      pending    <= pending_next;
      drop_count <= drop_next;
      fire       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            state_reg <= ISSUE;
            fire      <= 1'b1;
            fire_id   <= winner;
            last_reg  <= winner;
          end
        end
        ISSUE: begin
          cnt_reg   <= DT_W'(DEADTIME - 1);
          state_reg <= HOLD;
        end
        HOLD: begin
          // Counter parks at zero while busy stretches the deadtime.
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (!busy) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Randomized and directed bench for pulse_arbiter against a cycle-level
// behavioural model of the scheduling rules.
module tb_pulse_arbiter;
  localparam int N  = 4;
  localparam int DT = 8;

  logic         clock;
  logic         reset_n;
  logic [N-1:0] sig;
  logic         en, bz, clr;
  logic         fire, fire2;
  logic [1:0]   fire_id, fire_id2;
  logic [N-1:0] pending, pending2;
  logic [15:0]  drop_count;
  logic [1:0]   drop_count2;

  pulse_arbiter #(.N_CH(N), .ID_W(2), .DEADTIME(DT), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .signal(sig), .enable(en), .busy(bz),
    .drop_clear(clr), .fire(fire), .fire_id(fire_id), .pending(pending),
    .drop_count(drop_count)
  );

  pulse_arbiter #(.N_CH(N), .ID_W(2), .DEADTIME(DT), .CNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .signal(sig), .enable(en), .busy(bz),
    .drop_clear(clr), .fire(fire2), .fire_id(fire_id2), .pending(pending2),
    .drop_count(drop_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last_fire  = -1;

  // Behavioural model state
  logic [N-1:0] m_pend;
  logic [2:0]   m_samp [N];
  int           m_last, m_phase, m_id, m_drops, m_drops2;
  logic         m_fire;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend   = '0;
    m_last   = N - 1;
    m_phase  = -1;
    m_id     = 0;
    m_fire   = 1'b0;
    m_drops  = 0;
    m_drops2 = 0;
    for (int i = 0; i < N; i++) m_samp[i] = 3'b000;
    last_fire = -1;
  endtask

  // One clock edge of the reference: m_phase = -1 idle, 0 issue, k>=1 k-th hold cycle.
  task automatic model_edge();
    logic [N-1:0] rise_v, grant_v;
    int win, nd, c;
    win = -1;
    nd  = 0;
    grant_v = '0;
    for (int i = 0; i < N; i++) rise_v[i] = m_samp[i][1] & ~m_samp[i][2];
    if (m_phase < 0 && m_pend != 0 && en && !bz) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (win < 0 && m_pend[c]) win = c;
      end
      grant_v[win] = 1'b1;
    end
    if (m_phase < 0) begin
      if (win >= 0) m_phase = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase >= DT && !bz) begin
      m_phase = -1;
    end else begin
      m_phase++;
    end
    for (int i = 0; i < N; i++) begin
      if (rise_v[i] && m_pend[i] && !grant_v[i]) nd++;
      if (rise_v[i]) m_pend[i] = 1'b1;
      else if (grant_v[i]) m_pend[i] = 1'b0;
    end
    if (clr) begin
      m_drops  = 0;
      m_drops2 = 0;
    end else begin
      m_drops  = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
      m_drops2 = (m_drops2 + nd > 3) ? 3 : m_drops2 + nd;
    end
    m_fire = (win >= 0);
    if (win >= 0) begin
      m_id   = win;
      m_last = win;
    end
    for (int i = 0; i < N; i++) m_samp[i] = {m_samp[i][1:0], sig[i]};
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    chk("fire", fire, m_fire);
    chk("fire_id", fire_id, m_id);
    chk("pending", pending, m_pend);
    chk("drop_count", drop_count, m_drops);
    chk("drop_count_sat", drop_count2, m_drops2);
    if (fire) begin
      if (last_fire >= 0) chk("fire_gap_ok", (cyc - last_fire) >= DT + 2, 1);
      last_fire = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fire(input string tag);
    for (int i = 0; i < 40 && !fire; i++) tick();
    chk(tag, fire, 1);
  endtask

  task automatic pulse1(input int ch);
    sig[ch] = 1'b1; run(4);
    sig[ch] = 1'b0; run(4);
  endtask

  initial begin
    sig = '0; en = 1'b0; bz = 1'b0; clr = 1'b0; reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fire", fire, 0);
    chk("rst_fire_id", fire_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drops", drop_count, 0);
    reset_n = 1'b1;

    // Single request on channel 2
    en = 1'b1; sig[2] = 1'b1; run(16);

    // Round-robin over all channels, then 0 and 3 together
    sig = '0; run(4);
    sig = 4'hF; run(48);
    sig = '0; run(4);
    sig = 4'b1001; run(30);

    // Back-pressure held for 20 cycles after a fire
    sig = '0; run(4);
    sig = 4'b0110;
    wait_fire("bp_first_fire");
    tick();
    bz = 1'b1; run(20);
    bz = 1'b0; run(24);

    // Busy in IDLE blocks issue
    sig = '0; bz = 1'b1; run(4);
    sig = 4'b0001; run(10);
    chk("busy_blocks_pending", pending[0], 1);
    bz = 1'b0; run(16);

    // Drops with enable low, then clear together with a new drop
    sig = '0; en = 1'b0; run(4);
    pulse1(1); pulse1(1); pulse1(1);
    sig[1] = 1'b1; tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    sig[1] = 1'b0; run(4);
    for (int p = 0; p < 5; p++) pulse1(1);
    en = 1'b1; run(20);

    // Edge on channel 0 in the very cycle it is granted
    en = 1'b0; sig = '0; run(4);
    pulse1(0);
    sig[0] = 1'b1; tick(); tick();
    en = 1'b1; tick();
    chk("grant_edge_fire", fire, 1);
    chk("grant_edge_pend", pending[0], 1);
    run(20);

    // Reset during HOLD with channels 1 and 2 still pending
    sig = 4'b1000; run(4);
    wait_fire("ch3_fire");
    run(12);
    en = 1'b0; sig = 4'hF; run(5);
    en = 1'b1;
    wait_fire("pre_reset_fire");
    run(3);
    reset_n = 1'b0;
    #1;
    chk("midrst_fire", fire, 0);
    chk("midrst_fire_id", fire_id, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_drops", drop_count, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    run(50);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(5) == 0) sig[c] = ~sig[c];
      en  = ($urandom_range(7) != 0);
      bz  = ($urandom_range(4) == 0);
      clr = ($urandom_range(39) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pulse_arbiter.md
# pulse_arbiter

Multi-channel trigger scheduler that turns N asynchronous level inputs into single-cycle `fire` strobes for one shared downstream consumer, such as a readout or trigger-word builder. Each input is synchronized and rising-edge detected, then latched as a pending request. Pending requests are granted one at a time in round-robin order, with a minimum deadtime between grants and a downstream `busy` back-pressure input. Edges that arrive while their channel is still pending are counted as drops.

## Interface
- `N_CH`, 4: number of request channels (2..16).
- `ID_W`, 2: width of `fire_id`; must satisfy 2^ID_W >= N_CH.
- `DEADTIME`, 8: HOLD cycles after each grant (>= 1).
- `CNT_W`, 16: width of the drop counter.

- `clock`  in  1  single clock for all logic.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `signal`  in  N_CH  asynchronous level inputs, one per channel.
- `enable`  in  1  grant enable; while low, requests are collected but not issued.
- `busy`  in  1  downstream busy level, synchronous to `clock`.
- `drop_clear`  in  1  synchronous clear of `drop_count`.
- `fire`  out  1  single-cycle grant strobe, registered.
- `fire_id`  out  ID_W  index of the granted channel; valid while `fire`=1, holds its last value otherwise.
- `pending`  out  N_CH  registered pending-request bits.
- `drop_count`  out  CNT_W  saturating count of dropped edges.

## Operation
- **Per-channel front end**
  - Three flops: s1 <= signal, s2 <= s1, s3 <= s2.
  - edge = s2 & ~s3.
  - All three flops reset to 0. A level held high through reset release therefore produces one edge.
- **Pending update**, per channel, on every clock:
  - If edge=1 on the same clock that the channel is granted, the bit stays set. This is not a drop.
  - If edge=1 while the bit is set and the channel is not being granted, it is a drop; the bit stays 1.
  - Otherwise the next value is set when edge=1, cleared when the channel is granted, and held otherwise.
- **Drop counter**
  - Each cycle, `drop_count` increases by the number of channels that dropped in that cycle.
  - Saturates at 2^CNT_W-1.
  - `drop_clear`=1 forces 0 and takes priority; drops in that same cycle are not counted.
- **Round-robin**
  - Register `last` (reset N_CH-1).
  - The search starts at (last+1) mod N_CH and picks the first set `pending` bit in ascending modulo order.
  - `last` updates to the granted index on every grant.
- **FSM**
  - IDLE: if (`pending`!=0) & `enable` & ~`busy`, go to ISSUE. Otherwise stay.
  - ISSUE, one cycle: `fire`=1 and `fire_id`=winner; clear the winner's pending bit; load the deadtime counter with DEADTIME-1; go to HOLD.
  - HOLD: decrement the counter. When the counter is 0 and `busy`=0, go to IDLE; otherwise stay.
  - The winner is chosen from `pending` as registered in the IDLE cycle.
- `enable` falling during ISSUE/HOLD does not abort the grant; HOLD completes normally.
- `busy` is ignored in ISSUE. It only extends HOLD and blocks IDLE→ISSUE.
- **Reset (asynchronous, at any time)**
  - FSM to IDLE.
  - `fire`=0, `fire_id`=0, `pending`=0, `drop_count`=0, `last`=N_CH-1, counter=0.
  - In-flight requests are discarded.

## Timing
- **Input to pending:** `signal` first sampled high at clock edge k sets s1. Edge is high during cycle k+1..k+2, and `pending` is set at edge k+2.
- **Input to fire:** with the FSM idle, `enable`=1 and `busy`=0, `fire` is high during the cycle after edge k+3. That is 4 edges from first sample to `fire` asserted.
- **Grant spacing:** `fire` at cycle t allows the next `fire` no earlier than t+DEADTIME+2 (ISSUE, DEADTIME HOLD cycles, one IDLE cycle). `busy` extends HOLD cycle-for-cycle.
- **Pulse width:** `fire` is never high for two consecutive cycles.
- **Re-triggering:** an input must go low for at least 1 sampled cycle to re-trigger. Pulses narrower than one clock period may be missed.

## Test plan
- **Single request:** reset, `enable`=1, raise `signal`[2] and hold high → exactly one `fire` with `fire_id`=2, at the 4th edge after first sample; `pending`[2] clears on that edge; `drop_count`=0.
- **Round-robin:** raise `signal`[3:0]=4'b1111 in the same cycle, DEADTIME=8 → fire_ids 0,1,2,3 in order, consecutive fires exactly 10 cycles apart. Then raise channels 0 and 3 together → 0 first, then 3, because `last` was 3.
- **Back-pressure:** hold `busy`=1 from the cycle after a `fire` for 20 cycles with another request pending → next `fire` comes 2 cycles after `busy` falls (HOLD→IDLE, then ISSUE). Raising `busy` in IDLE blocks issue.
- **Drops:** pulse `signal`[1] three times, 4 cycles high / 4 low each, with `enable`=0 → `pending`[1]=1, `drop_count`=2. Then assert `drop_clear` together with a new drop → `drop_count`=0. With CNT_W=2, force 5 drops → saturates at 3.
- **Grant-cycle edge:** arrange for an edge on channel 0 in the same cycle channel 0 is granted → `pending`[0] stays 1, no drop, and a second `fire` with `fire_id`=0 follows.
- **Reset mid-HOLD:** assert `reset_n`=0 for 1 cycle during HOLD with `pending`=4'b0110 → all outputs 0 immediately; after release, with all inputs still high, each channel regenerates an edge and is granted in order 0,1,2,3.
